turnstile_controller: RTL and testbench
=======================================

# turnstile_controller

Parametrised fare-gate controller. It accumulates coin credit, unlocks the gate when the stored credit covers a configurable price, and counts entries. It raises an alarm on a forced push and can optionally relock on an inactivity timeout. It sits between the debounced coin/push sensor front end and the gate actuator and status logic.

## Interface
- PRICE, 2: coins consumed per entry; legal range 1..MAX_CREDIT.
- MAX_CREDIT, 7: saturation limit of the credit store.
- COUNT_W, 16: width of the entry counter.
- TIMEOUT_CYCLES, 1000: cycles in UNLOCKED without a push before auto-relock (≥2). Only used with TURNSTILE_TIMEOUT_EN.
- CREDIT_W (localparam): $clog2(MAX_CREDIT+1).

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Coin  in  1  single-cycle coin strobe; each high cycle is one coin.
- i_Push  in  1  single-cycle push strobe.
- i_Alarm_Clr  in  1  operator alarm clear.
- o_Locked  out  1  1 unless state is UNLOCKED.
- o_Alarm  out  1  1 in ALARM.
- o_Credit  out  CREDIT_W  stored credit.
- o_Entries  out  COUNT_W  completed entries; wraps modulo 2^COUNT_W.
- o_Coin_Reject  out  1  one-cycle pulse for a coin that was not credited.
- o_Timeout  out  1  one-cycle pulse on auto-relock (tied 0 without the macro).

## Operation
- Reset values: state LOCKED, o_Locked=1, o_Alarm=0, o_Credit=0, o_Entries=0, o_Coin_Reject=0, o_Timeout=0, timer=0.
- credit_acc = credit + coin, where coin means i_Coin high and credit < MAX_CREDIT. A coin arriving at MAX_CREDIT is dropped and pulses o_Coin_Reject.
- LOCKED:
  - If i_Push is high, go to ALARM. The coin is still credited, and no unlock happens.
  - Else, if credit_acc ≥ PRICE, go to UNLOCKED with credit ← credit_acc − PRICE.
  - Else, credit ← credit_acc.
  - Stored credit ≥ PRICE unlocks without a new coin.
- UNLOCKED:
  - Coins accumulate (saturating).
  - i_Push → LOCKED, o_Entries +1, timer cleared.
  - A simultaneous coin is credited.
- ALARM:
  - Gate is locked. Every coin is rejected (o_Coin_Reject pulse) and credit is frozen.
  - i_Push is ignored.
  - i_Alarm_Clr → LOCKED.
  - The unlock check resumes in the following cycle.
- i_Alarm_Clr has no effect outside ALARM.
- Invalid state encoding recovers to LOCKED.

## Timing
- All outputs are registered or decoded directly from registered state. There is no combinational input-to-output path.
- Input sampled at edge N → state, credit and pulses visible after edge N (1-cycle latency). Pulses last exactly one cycle.
- Timeout:
  - The timer counts the cycles spent in UNLOCKED.
  - On the cycle where timer = TIMEOUT_CYCLES−1 with no push, state → LOCKED and o_Timeout pulses. The fare is forfeited and entries are unchanged.
  - A push on that same cycle wins: it counts as an entry and no timeout fires.
- Reset mid-operation: immediate return to reset values. The in-flight coin is lost.

## Configuration
- TURNSTILE_TIMEOUT_EN:
  - When defined, the timer and auto-relock are present.
  - When undefined, there is no timer logic, UNLOCKED persists until a push, o_Timeout is constant 0, and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package turnstile_pkg:
  - 2-bit state encodings ST_LOCKED=2'd0, ST_UNLOCKED=2'd1, ST_ALARM=2'd2.
  - The state typedef.
- Sub-module turnstile_timer, instantiated only under TURNSTILE_TIMEOUT_EN:
  - Inputs: clear and run enable.
  - Output: single-cycle expiry pulse.
  - Parameter: TIMEOUT_CYCLES.
- FSM, credit arithmetic and entry counter live in turnstile_controller.

## Test plan
Bench uses PRICE=2, MAX_CREDIT=3, TIMEOUT_CYCLES=8.
- Two coins on consecutive cycles from reset → credit 1, then o_Locked=0 with credit 0 one cycle after the second coin; a push → o_Locked=1, o_Entries=1.
- Four coins while UNLOCKED, then push → credit saturates at 3; the 4th coin pulses o_Coin_Reject; after the push, next cycle unlocks with credit 1, no coin needed.
- Push while LOCKED with credit 1 → o_Alarm=1; a coin during the alarm is rejected and credit stays 1; i_Alarm_Clr → LOCKED, o_Alarm=0.
- Macro on: unlock, then no push for 8 cycles → o_Timeout single pulse, o_Locked=1, o_Entries unchanged; a push exactly on the 8th cycle → entry counted, no timeout.
- Simultaneous coin and push in LOCKED with credit 1 → ALARM with credit 2, no unlock. Reset asserted mid-UNLOCKED → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/turnstile_pkg.sv
// turnstile_pkg: types shared by the turnstile fare-gate controller files.
//   state_t : gate FSM state, 2-bit encoding (3 is unused and recovers to LOCKED).
package turnstile_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ALARM    = 2'd2
    } state_t;

endpackage

// File: rtl/turnstile_if.sv
// turnstile_if: sensor-side strobes and gate/status outputs of the fare gate.
//   i_Coin, i_Push, i_Alarm_Clr : single-cycle strobes from the sensor front end
//   o_Locked, o_Alarm           : gate actuator / status levels
//   o_Credit, o_Entries         : stored credit, completed entry count
//   o_Coin_Reject, o_Timeout    : one-cycle event pulses
// master drives the strobes (sensor side); slave is the controller.
interface turnstile_if #(
    parameter int CREDIT_W = 3,
    parameter int COUNT_W  = 16
);
    logic                i_Coin;
    logic                i_Push;
    logic                i_Alarm_Clr;
    logic                o_Locked;
    logic                o_Alarm;
    logic [CREDIT_W-1:0] o_Credit;
    logic [COUNT_W-1:0]  o_Entries;
    logic                o_Coin_Reject;
    logic                o_Timeout;

    modport master (
        output i_Coin, i_Push, i_Alarm_Clr,
        input  o_Locked, o_Alarm, o_Credit, o_Entries, o_Coin_Reject, o_Timeout
    );

    modport slave (
        input  i_Coin, i_Push, i_Alarm_Clr,
        output o_Locked, o_Alarm, o_Credit, o_Entries, o_Coin_Reject, o_Timeout
    );
endinterface

// File: rtl/turnstile_timer.sv
// turnstile_timer: inactivity timer for the UNLOCKED state.
//   i_Clk, i_Reset : clock, async active-high reset
//   i_Run          : gate is UNLOCKED; counter is held at 0 otherwise
//   i_Clear        : restart the count (a push)
//   o_Expire       : high on the cycle the count reaches TIMEOUT_CYCLES-1
// o_Expire is decoded from the registered count and i_Run (registered state),
// so it lasts one cycle: the controller leaves UNLOCKED on that edge.
module turnstile_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Run,
    input  logic i_Clear,
    output logic o_Expire
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] cnt;

    assign o_Expire = i_Run && (cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            cnt <= '0;
        else if (!i_Run || i_Clear || o_Expire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/turnstile_controller.sv
// turnstile_controller: fare-gate FSM with coin credit store and entry counter.
//   i_Clk, i_Reset : clock, async active-high reset
//   bus (slave)    : i_Coin/i_Push/i_Alarm_Clr strobes in; o_Locked, o_Alarm,
//                    o_Credit, o_Entries, o_Coin_Reject, o_Timeout out
// Optional feature macro TURNSTILE_TIMEOUT_EN: adds turnstile_timer and relocks
// the gate after TIMEOUT_CYCLES idle cycles in UNLOCKED; without it o_Timeout
// is 0 and UNLOCKED waits for a push.
// All outputs come from registers or registered state.
module turnstile_controller
    import turnstile_pkg::*;
#(
    parameter int PRICE          = 2,
    parameter int MAX_CREDIT     = 7,
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    turnstile_if.slave bus
);
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);

    if (PRICE < 1 || PRICE > MAX_CREDIT) begin : g_bad_price
        $error("turnstile_controller: PRICE must be in 1..MAX_CREDIT");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, credit_acc;
    logic [COUNT_W-1:0]  entries_q;
    logic                reject_q, reject_d;
    logic                timeout_q, timeout_d;
    logic                coin_ok, entry, expire;

`ifdef TURNSTILE_TIMEOUT_EN
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("turnstile_controller: TIMEOUT_CYCLES must be >= 2");
    end

    turnstile_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Run    (state_q == ST_UNLOCKED),
        .i_Clear  (bus.i_Push),
        .o_Expire (expire)
    );
`else
    // TIMEOUT_CYCLES is accepted but has no effect in this build.
    if (TIMEOUT_CYCLES < 0) begin : g_unused_timeout
        $error("turnstile_controller: TIMEOUT_CYCLES must not be negative");
    end

    assign expire = 1'b0;
`endif

    always_comb begin
        // ALARM freezes the store, and a full store drops the coin.
        coin_ok    = bus.i_Coin && (state_q != ST_ALARM) &&
                     (credit_q < CREDIT_W'(MAX_CREDIT));
        reject_d   = bus.i_Coin && !coin_ok;
        credit_acc = credit_q + CREDIT_W'(coin_ok);

        state_d   = state_q;
        credit_d  = credit_q;
        entry     = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                credit_d = credit_acc;
                if (bus.i_Push) begin
                    state_d = ST_ALARM;
                end else if (credit_acc >= CREDIT_W'(PRICE)) begin
                    state_d  = ST_UNLOCKED;
                    credit_d = credit_acc - CREDIT_W'(PRICE);
                end
            end
            ST_UNLOCKED: begin
                credit_d = credit_acc;
                // A push on the expiry cycle still counts as an entry.
                if (bus.i_Push) begin
                    state_d = ST_LOCKED;
                    entry   = 1'b1;
                end else if (expire) begin
                    state_d   = ST_LOCKED;
                    timeout_d = 1'b1;
                end
            end
            ST_ALARM: begin
                if (bus.i_Alarm_Clr)
                    state_d = ST_LOCKED;
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_LOCKED;
            credit_q  <= '0;
            entries_q <= '0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            if (entry)
                entries_q <= entries_q + 1'b1;
        end
    end

    assign bus.o_Locked      = (state_q != ST_UNLOCKED);
    assign bus.o_Alarm       = (state_q == ST_ALARM);
    assign bus.o_Credit      = credit_q;
    assign bus.o_Entries     = entries_q;
    assign bus.o_Coin_Reject = reject_q;
    assign bus.o_Timeout     = timeout_q;
endmodule

// File: tb/tb_turnstile_controller.sv
// tb_turnstile_controller: directed walk through the gate scenarios followed by
// random coin/push/clear/reset traffic, every cycle compared against a
// behavioural model of the fare rules. Works with or without TURNSTILE_TIMEOUT_EN.
module tb_turnstile_controller;
    localparam int PRICE          = 2;
    localparam int MAX_CREDIT     = 3;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int COUNT_W        = 16;
    localparam int CREDIT_W       = 2;
`ifdef TURNSTILE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic i_Clk = 1'b0;
    logic i_Reset;

    turnstile_if #(.CREDIT_W(CREDIT_W), .COUNT_W(COUNT_W)) bus ();

    turnstile_controller #(
        .PRICE          (PRICE),
        .MAX_CREDIT     (MAX_CREDIT),
        .COUNT_W        (COUNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clk = ~i_Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: gate mode, coins held, people admitted, idle cycles open.
    typedef enum int {M_CLOSED, M_OPEN, M_ALARMED} mode_t;
    mode_t m_mode;
    int    m_coins, m_people, m_idle;
    bit    m_rej, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_CLOSED; m_coins = 0; m_people = 0; m_idle = 0;
        m_rej = 0; m_to = 0;
    endtask

    task automatic model_step(input bit c, input bit p, input bit a);
        int got;
        got   = (c && m_mode != M_ALARMED && m_coins < MAX_CREDIT) ? 1 : 0;
        m_rej = c && (got == 0);
        m_to  = 0;
        case (m_mode)
            M_CLOSED: begin
                m_coins += got;
                if (p) m_mode = M_ALARMED;
                else if (m_coins >= PRICE) begin
                    m_coins -= PRICE;
                    m_mode  = M_OPEN;
                    m_idle  = 0;
                end
            end
            M_OPEN: begin
                m_coins += got;
                if (p) begin
                    m_people++;
                    m_mode = M_CLOSED;
                end else if (TO_EN && m_idle + 1 == TIMEOUT_CYCLES) begin
                    m_mode = M_CLOSED;
                    m_to   = 1;
                end else m_idle++;
            end
            default: if (a) m_mode = M_CLOSED;
        endcase
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".locked"},  bus.o_Locked,        m_mode != M_OPEN);
        chk({ctx, ".alarm"},   bus.o_Alarm,         m_mode == M_ALARMED);
        chk({ctx, ".credit"},  bus.o_Credit,        m_coins);
        chk({ctx, ".entries"}, bus.o_Entries,       m_people % (1 << COUNT_W));
        chk({ctx, ".reject"},  bus.o_Coin_Reject,   m_rej);
        chk({ctx, ".timeout"}, bus.o_Timeout,       m_to);
    endtask

    task automatic step(input bit c, input bit p, input bit a, input string ctx);
        @(negedge i_Clk);
        bus.i_Coin = c; bus.i_Push = p; bus.i_Alarm_Clr = a;
        @(posedge i_Clk);
        model_step(c, p, a);
        #1;
        check_all(ctx);
    endtask

    // Asynchronous reset applied mid-cycle; outputs checked before any edge.
    task automatic async_reset(input string ctx);
        @(negedge i_Clk);
        #2;
        bus.i_Coin = 0; bus.i_Push = 0; bus.i_Alarm_Clr = 0;
        i_Reset = 1'b1;
        #1;
        model_reset();
        check_all(ctx);
        @(negedge i_Clk);
        i_Reset = 1'b0;
    endtask

    initial begin
        bus.i_Coin = 0; bus.i_Push = 0; bus.i_Alarm_Clr = 0;
        i_Reset = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset = 1'b0;

        // Two coins unlock; push admits one.
        step(1, 0, 0, "coin1");
        step(1, 0, 0, "coin2");
        step(0, 1, 0, "entry1");

        // Saturation while open; stored credit unlocks without a coin.
        step(1, 0, 0, "s_c1");
        step(1, 0, 0, "s_c2");
        for (int i = 0; i < 4; i++) step(1, 0, 0, "sat");
        step(0, 1, 0, "s_push");
        step(0, 0, 0, "s_reopen");
        step(0, 1, 0, "s_push2");

        // Forced push with credit 1; coin during alarm rejected.
        step(0, 1, 0, "al_push");
        step(1, 0, 0, "al_coin");
        step(0, 1, 0, "al_ignpush");
        step(0, 0, 1, "al_clr");
        step(0, 0, 0, "al_idle");

        // Inactivity: 8 idle cycles after unlock, then a few more.
        step(1, 0, 0, "to_unlock");
        for (int i = 0; i < TIMEOUT_CYCLES + 3; i++) step(0, 0, 0, "to_idle");
        if (!TO_EN) step(0, 1, 0, "to_close");

        // Push on the last allowed cycle wins over the timeout.
        step(1, 0, 0, "pw_c1");
        step(1, 0, 0, "pw_c2");
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(0, 0, 0, "pw_idle");
        step(0, 1, 0, "pw_push");
        step(0, 0, 0, "pw_after");

        // Coin+push in LOCKED: credited, alarm, no unlock.
        step(1, 0, 0, "cp_c");
        step(1, 1, 0, "cp_both");
        step(0, 0, 1, "cp_clr");
        step(0, 0, 0, "cp_open");
        async_reset("rst_open");
        step(0, 0, 0, "post_rst");

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0)
                async_reset("rnd_rst");
            else
                step(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
